// File: rtl/audio_pkg.sv
// audio_pkg: shared frame geometry and default divider constants for the DAC serializer
package audio_pkg;
  localparam int SLOT_BITS     = 32;
  localparam int FRAME_BITS    = 64;
  localparam int IDX_W         = $clog2(FRAME_BITS);
  localparam int POS_W         = $clog2(SLOT_BITS);
  localparam int BCLK_HALF_DEF = 8;
  localparam int MCLK_HALF_DEF = 2;
endpackage

// File: rtl/audio_dac_serializer_clk_div_toggle.sv
// clk_div_toggle: divide-by-2*HALF clock whose level toggles every HALF cycles
// Ports: clk, rst_n (async active-low), q = divided clock level,
//        fall = high in the cycle whose closing edge drives q from 1 to 0
module clk_div_toggle #(
  parameter int HALF = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic q,
  output logic fall
);
  localparam int W = HALF > 1 ? $clog2(HALF) : 1;
  logic [W-1:0] cnt;
  logic         wrap;
  assign wrap = cnt == W'(HALF - 1);
  assign fall = wrap && q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      q   <= 1'b0;
    end else begin
      cnt <= wrap ? '0 : cnt + W'(1);
      q   <= q ^ wrap;
    end
endmodule

// File: rtl/audio_dac_serializer.sv
// audio_dac_serializer: mono sample to codec serial stream with MCLK/BCLK/LRCK generation
// Ports: CLOCK_50 clock, resetn async active-low reset, sample_in mono sample,
//        mute silences whole frames, aud_xck/aud_bclk/aud_daclrck/aud_dacdat codec pins,
//        sample_tick one-cycle pulse per frame.
// Build option: define AUDIO_SER_LEFTJ_EN for left-justified slots (default I2S).
module audio_dac_serializer
  import audio_pkg::*;
#(
  parameter int SAMPLE_W  = 16,
  parameter int BCLK_HALF = BCLK_HALF_DEF,
  parameter int MCLK_HALF = MCLK_HALF_DEF
) (
  input  logic                CLOCK_50,
  input  logic                resetn,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                mute,
  output logic                aud_xck,
  output logic                aud_bclk,
  output logic                aud_daclrck,
  output logic                aud_dacdat,
  output logic                sample_tick
);
  logic                 bclk_fall;
  logic                 mclk_fall_unused;
  logic [IDX_W-1:0]     bit_idx;
  logic [IDX_W-1:0]     nxt_idx;
  logic [POS_W-1:0]     pos;
  logic [SAMPLE_W-1:0]  hold;
  logic                 mute_q;
  logic [SLOT_BITS-1:0] slot;
  logic                 latch;
  logic                 dat_nxt;

  clk_div_toggle #(.HALF(MCLK_HALF)) u_mclk (
    .clk  (CLOCK_50),
    .rst_n(resetn),
    .q    (aud_xck),
    .fall (mclk_fall_unused)
  );

  clk_div_toggle #(.HALF(BCLK_HALF)) u_bclk (
    .clk  (CLOCK_50),
    .rst_n(resetn),
    .q    (aud_bclk),
    .fall (bclk_fall)
  );

  // The slot word is laid out MSB-first so slot position p reads bit ~p.
`ifdef AUDIO_SER_LEFTJ_EN
  assign slot = SLOT_BITS'(hold) << (SLOT_BITS - SAMPLE_W);
`else
  assign slot = SLOT_BITS'(hold) << (SLOT_BITS - 1 - SAMPLE_W);
`endif

  assign nxt_idx     = bit_idx + IDX_W'(1);
  assign pos         = nxt_idx[POS_W-1:0];
  assign latch       = bclk_fall && bit_idx == IDX_W'(FRAME_BITS - 2);
  // hold only changes going into position 63, whose slot bit still belongs to
  // the outgoing frame, so the current hold is always the right source here.
  assign dat_nxt     = !mute_q && slot[~pos];
  assign aud_daclrck = bit_idx[IDX_W-1];

  always_ff @(posedge CLOCK_50 or negedge resetn)
    if (!resetn) begin
      bit_idx     <= '0;
      hold        <= '0;
      mute_q      <= 1'b0;
      aud_dacdat  <= 1'b0;
      sample_tick <= 1'b0;
    end else begin
      sample_tick <= latch;
      if (bclk_fall) begin
        bit_idx    <= nxt_idx;
        aud_dacdat <= dat_nxt;
      end
      if (latch) begin
        hold   <= sample_in;
        mute_q <= mute;
      end
    end
endmodule
